// File: rtl/mult_pkg.sv
// Shared widths and FSM state type for the shift-and-add multiplier.
package mult_pkg;

    localparam int WIDTH_A = 16;
    localparam int WIDTH_B = 4;
    localparam int WIDTH_P = 32;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_dp.sv
// Operand, accumulator and bit-counter registers with the partial-sum adder.
module shift_add_multiplier_dp
    import mult_pkg::*;
#(
    parameter int WA = WIDTH_A,
    parameter int WB = WIDTH_B,
    parameter int WP = WIDTH_P
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          run,
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    output logic [WP-1:0] sum,
    output logic          last
);

    localparam int CW = (WB > 1) ? $clog2(WB) : 1;

    logic [WP-1:0] a_reg;
    logic [WB-1:0] b_reg;
    logic [WP-1:0] acc;
    logic [CW-1:0] cnt;

    // Sum already includes this cycle's bit so the final value can be published directly.
    assign sum  = b_reg[0] ? acc + a_reg : acc;
    assign last = (cnt == CW'(WB - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= {{(WP-WA){1'b0}}, a};
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (run) begin
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            acc   <= sum;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Free-running unsigned shift-and-add multiplier: one multiplier bit per clock,
// product registered at the end of each pass.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH_A = mult_pkg::WIDTH_A,
    parameter int WIDTH_B = mult_pkg::WIDTH_B,
    parameter int WIDTH_P = mult_pkg::WIDTH_P
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    output logic [WIDTH_P-1:0] outProduct
);

    state_t state;
    state_t state_next;

    logic               load;
    logic               run;
    logic               done;
    logic               last;
    logic [WIDTH_P-1:0] sum;

    shift_add_multiplier_dp #(
        .WA(WIDTH_A),
        .WB(WIDTH_B),
        .WP(WIDTH_P)
    ) u_dp (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .run  (run),
        .a    (A),
        .b    (B),
        .sum  (sum),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        run        = 1'b0;
        done       = 1'b0;
        unique case (state)
            LOAD: begin
                load       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                run = 1'b1;
                if (last) begin
                    done       = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outProduct <= '0;
        end else if (done) begin
            outProduct <= sum;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised and directed bench for shift_add_multiplier against a pass-level model.
module tb_shift_add_multiplier;

    localparam int WA = 16;
    localparam int WB = 4;
    localparam int WP = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [WA-1:0] A = 16'd6;
    logic [WB-1:0] B = 4'd5;
    logic [WP-1:0] outProduct;

    int vectors = 0;
    int miscompares = 0;

    // Model: a pass samples operands on its first edge and publishes a*b WB edges later.
    logic [WP-1:0] exp_p = '0;
    logic [WA-1:0] sa = '0;
    logic [WB-1:0] sb = '0;
    int            pos = 0;
    bit            model_valid = 1'b0;

    shift_add_multiplier dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .outProduct(outProduct)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            exp_p = '0;
            pos = 0;
            model_valid = 1'b1;
        end else if (pos == 0) begin
            sa = A;
            sb = B;
            pos = 1;
        end else if (pos == WB) begin
            exp_p = WP'(sa) * WP'(sb);
            pos = 0;
        end else begin
            pos = pos + 1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            vectors++;
            if (outProduct !== exp_p) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got=%0d expected=%0d", $time, outProduct, exp_p);
            end
        end
    end

    task automatic check_lit(input string name, input logic [WP-1:0] val);
        vectors++;
        if (outProduct !== val) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, outProduct, val);
        end
    endtask

    task automatic wait_val(input string name, input logic [WP-1:0] val, input int n);
        bit hit = 1'b0;
        for (int i = 0; i < n && !hit; i++) begin
            @(negedge clk);
            #1;
            if (outProduct === val) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d within %0d clocks", name, outProduct, val, n);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        A = 16'd6;
        B = 4'd5;
        idle(50);
        check_lit("reset_hold", 32'd0);

        @(negedge clk);
        reset = 1'b0;
        wait_val("first_30", 32'd30, WB + 2);
        idle(12);
        check_lit("hold_30", 32'd30);

        A = 16'd7;
        B = 4'd8;
        wait_val("to_56", 32'd56, 2 * (WB + 1) + 1);
        idle(6);
        check_lit("hold_56", 32'd56);

        A = 16'hFFFF;
        B = 4'hF;
        wait_val("max", 32'h000E_FFF1, 2 * (WB + 1) + 1);
        idle(6);
        check_lit("hold_max", 32'd983025);

        A = 16'd1234;
        B = 4'd0;
        wait_val("b_zero", 32'd0, 2 * (WB + 1) + 1);

        A = 16'd0;
        B = 4'd11;
        idle(2 * (WB + 1));
        check_lit("a_zero", 32'd0);

        // Align a pass with a one-cycle reset, then swap operands mid-pass.
        @(negedge clk);
        reset = 1'b1;
        A = 16'd3;
        B = 4'd3;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        A = 16'd100;
        B = 4'd9;
        wait_val("midrun_first", 32'd9, WB + 1);
        wait_val("midrun_next", 32'd900, WB + 2);

        A = 16'd5;
        B = 4'd7;
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_lit("abort_zero", 32'd0);
        reset = 1'b0;
        wait_val("after_abort", 32'd35, WB + 2);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: A = 16'hFFFF;
                    1: A = 16'h0000;
                    default: A = WA'($urandom);
                endcase
                B = WB'($urandom);
            end
            reset = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(3 * (WB + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
